seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clock cycles per digit slot (legal range 4..2^20).
REQ-002 SHALL have parameter BLANK_CYC, default 2, cycles at the start of each slot with all anodes off (anti-ghosting); BLANK_CYC < SCAN_DIV.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port data  input  32  eight hex digits; nibble i (data[4i+3:4i]) drives digit i, digit 0 rightmost.
REQ-006 SHALL have port dp  input  8  decimal point per digit, 1 = lit.
REQ-007 SHALL have port load  input  1  when high at a clock edge, data/dp/blank_lz are captured into the pending register.
REQ-008 SHALL have port blank_lz  input  1  leading-zero blanking enable.
REQ-009 SHALL have port seg  output  8  {dp,g,f,e,d,c,b,a}, active-low, registered.
REQ-010 SHALL have port an  output  8  digit anodes, active-low, one-hot-low or all high, registered.
REQ-011 SHALL have port frame_tick  output  1  one-cycle pulse at each frame boundary.

Function
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; at terminal count, digit index (3 bits) SHALL advance 0->1->...->7->0.
REQ-013 Frame boundary SHALL be the cycle in which the prescaler is at terminal count and the digit index is 7; frame_tick SHALL be high in the following cycle only.
REQ-014 On load, the pending register SHALL capture data, dp and blank_lz and set pending_valid; a later load before the boundary SHALL overwrite it.
REQ-015 At a frame boundary with pending_valid=1, pending SHALL copy to the active register and pending_valid SHALL clear; active SHALL never change at any other time (no mid-frame tearing).
REQ-016 If load and the frame boundary coincide, the boundary SHALL transfer the previously pending contents, and the new load SHALL be stored as pending with pending_valid=1 for the next boundary; if no prior pending existed, active is unchanged this boundary.
REQ-017 While the prescaler is < BLANK_CYC, next-cycle an SHALL be 8'hFF and seg 8'hFF; otherwise an SHALL be ~(1<<idx) and seg SHALL be the encoding of active nibble idx.
REQ-018 Hex encoding (seg[6:0], active-low): 0 40,1 79,2 24,3 30,4 19,5 12,6 02,7 78,8 00,9 10,A 08,b 03,C 46,d 21,E 06,F 0E; seg[7] = ~dp[idx].
REQ-019 With active blank_lz=1, digit i SHALL be blanked (seg=8'hFF, an still driven) when i > index of the highest nonzero nibble; digit 0 SHALL never be blanked; a digit whose dp bit is set SHALL not be blanked.
REQ-020 seg/an SHALL be registered: values at edge k reflect prescaler/index state before edge k (one-cycle latency).

Reset
REQ-021 While rstn=0 at a clock edge: prescaler=0, idx=0, active and pending registers=0, pending_valid=0, seg=8'hFF, an=8'hFF, frame_tick=0.
REQ-022 Reset asserted mid-frame SHALL discard pending data and restart scanning at digit 0 on the first edge after release; load sampled while rstn=0 SHALL be ignored.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-023 Reset release, no load -> an all high for slot cycles 0-1, then an=FE with seg=C0; digit order FE,FD,...,7F repeating every 64 cycles; frame_tick every 64 cycles.
REQ-024 load data=32'h12345678, dp=0 mid-frame -> display unchanged until boundary; next frame digit0 seg=80 (8), digit7 seg=F9 (1).
REQ-025 data=32'h0000_00A5, blank_lz=1, dp=8'h04 -> digits 0,1,2 lit (A4? no: 92,88, dp only C0&7F=40 on digit 2), digits 3-7 seg=FF.
REQ-026 load asserted exactly in boundary cycle with earlier pending value P and new value N -> frame after shows P, following frame shows N.
REQ-027 rstn low for 1 cycle mid-slot of digit 5 with pending load -> outputs FF/FF, next frame shows zeros, pending lost.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed 7-segment scanner with frame-synchronous double
// buffering, per-slot anode blanking and optional leading-zero suppression.
module seg_scan_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic        load,
  input  logic        blank_lz,
  output logic [7:0]  seg,
  output logic [7:0]  an,
  output logic        frame_tick
);

  localparam int            PW    = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] TC    = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK = PW'(BLANK_CYC);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;

  logic [31:0]   r_pend_data;
  logic [7:0]    r_pend_dp;
  logic          r_pend_blz;
  logic          r_pend_valid;

  logic [31:0]   r_act_data;
  logic [7:0]    r_act_dp;
  logic          r_act_blz;

  logic [7:0]    r_seg;
  logic [7:0]    r_an;
  logic          r_tick;

  logic          w_tc;
  logic          w_boundary;
  logic [3:0]    w_nib;
  logic [2:0]    w_hi;
  logic          w_blank;
  logic [6:0]    w_glyph;
  logic [7:0]    w_seg_nxt;
  logic [7:0]    w_an_nxt;

  assign w_tc       = (r_presc == TC);
  assign w_boundary = w_tc && (r_idx == 3'd7);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_presc <= '0;
      r_idx   <= 3'd0;
    end else if (w_tc) begin
      r_presc <= '0;
      r_idx   <= r_idx + 3'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // A load coinciding with the boundary lands in pending; the boundary itself
  // only ever transfers what was pending before that edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pend_data  <= 32'd0;
      r_pend_dp    <= 8'd0;
      r_pend_blz   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_act_data   <= 32'd0;
      r_act_dp     <= 8'd0;
      r_act_blz    <= 1'b0;
    end else begin
      if (w_boundary && r_pend_valid) begin
        r_act_data <= r_pend_data;
        r_act_dp   <= r_pend_dp;
        r_act_blz  <= r_pend_blz;
      end
      if (load) begin
        r_pend_data  <= data;
        r_pend_dp    <= dp;
        r_pend_blz   <= blank_lz;
        r_pend_valid <= 1'b1;
      end else if (w_boundary) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // Highest nonzero nibble; an all-zero word resolves to 0 so digit 0 stays lit.
  always_comb begin
    w_hi = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (r_act_data[4*i +: 4] != 4'd0) w_hi = i[2:0];
    end
  end

  assign w_nib   = r_act_data[{r_idx, 2'b00} +: 4];
  assign w_blank = r_act_blz && (r_idx > w_hi) && !r_act_dp[r_idx];

  always_comb begin
    w_glyph = 7'h7F;
    case (w_nib)
      4'h0: w_glyph = 7'h40;
      4'h1: w_glyph = 7'h79;
      4'h2: w_glyph = 7'h24;
      4'h3: w_glyph = 7'h30;
      4'h4: w_glyph = 7'h19;
      4'h5: w_glyph = 7'h12;
      4'h6: w_glyph = 7'h02;
      4'h7: w_glyph = 7'h78;
      4'h8: w_glyph = 7'h00;
      4'h9: w_glyph = 7'h10;
      4'hA: w_glyph = 7'h08;
      4'hB: w_glyph = 7'h03;
      4'hC: w_glyph = 7'h46;
      4'hD: w_glyph = 7'h21;
      4'hE: w_glyph = 7'h06;
      4'hF: w_glyph = 7'h0E;
      default: w_glyph = 7'h7F;
    endcase
  end

  always_comb begin
    w_seg_nxt = 8'hFF;
    w_an_nxt  = 8'hFF;
    if (r_presc >= BLANK) begin
      w_an_nxt = ~(8'h01 << r_idx);
      if (!w_blank) w_seg_nxt = {~r_act_dp[r_idx], w_glyph};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_seg  <= 8'hFF;
      r_an   <= 8'hFF;
      r_tick <= 1'b0;
    end else begin
      r_seg  <= w_seg_nxt;
      r_an   <= w_an_nxt;
      r_tick <= w_boundary;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver at SCAN_DIV=8, BLANK_CYC=2 (64-cycle frame).
// t counts rising edges with rstn high since the last release.
module tb_seg_scan_driver;

  logic        clk;
  logic        rstn;
  logic [31:0] data;
  logic [7:0]  dp;
  logic        load;
  logic        blank_lz;
  logic [7:0]  seg;
  logic [7:0]  an;
  logic        frame_tick;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;

  seg_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .data       (data),
    .dp         (dp),
    .load       (load),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    if (rstn) t++;
    @(negedge clk);
  endtask

  task automatic go_to(input int pos);
    for (int k = 0; k < 64; k++) begin
      if (t % 64 == pos) break;
      step();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; load = 1'b1; data = 32'hFFFF_FFFF; dp = 8'hFF; blank_lz = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (seg !== 8'hFF || an !== 8'hFF || frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: seg=%h an=%h tick=%b, need seg=FF an=FF tick=0", seg, an, frame_tick);
      end
    end
    load = 1'b0; data = 32'd0; dp = 8'd0; blank_lz = 1'b0;
  endtask

  // Active stays zero (load during reset ignored): every digit shows C0.
  task automatic test_scan();
    int c, p, i;
    logic [7:0] e_an, e_seg;
    logic       e_tick;
    rstn = 1'b1;
    t = 0;
    for (int k = 1; k <= 130; k++) begin
      step();
      c = t - 1; p = c % 8; i = (c / 8) % 8;
      e_an   = (p < 2) ? 8'hFF : ~(8'h01 << i);
      e_seg  = (p < 2) ? 8'hFF : 8'hC0;
      e_tick = (t % 64 == 0);
      n_checks++;
      if (an !== e_an || seg !== e_seg || frame_tick !== e_tick) begin
        n_fail++;
        $display("FAIL scan t=%0d: an=%h seg=%h tick=%b, need an=%h seg=%h tick=%b",
                 t, an, seg, frame_tick, e_an, e_seg, e_tick);
      end
    end
  endtask

  task automatic test_load_sync();
    go_to(20);
    load = 1'b1; data = 32'h1234_5678; dp = 8'h00; blank_lz = 1'b0;
    step();
    load = 1'b0;
    go_to(61);
    n_checks++;
    if (an !== 8'h7F || seg !== 8'hC0) begin
      n_fail++;
      $display("FAIL no_tearing: an=%h seg=%h, need an=7F seg=C0", an, seg);
    end
    go_to(5);
    n_checks++;
    if (an !== 8'hFE || seg !== 8'h80) begin
      n_fail++;
      $display("FAIL load_digit0: an=%h seg=%h, need an=FE seg=80", an, seg);
    end
    go_to(29);
    n_checks++;
    if (an !== 8'hF7 || seg !== 8'h92) begin
      n_fail++;
      $display("FAIL load_digit3: an=%h seg=%h, need an=F7 seg=92", an, seg);
    end
    go_to(61);
    n_checks++;
    if (an !== 8'h7F || seg !== 8'hF9) begin
      n_fail++;
      $display("FAIL load_digit7: an=%h seg=%h, need an=7F seg=F9", an, seg);
    end
  endtask

  task automatic test_blank_lz();
    logic [7:0] exp_seg [8] = '{8'h92, 8'h88, 8'h40, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0] e_an;
    go_to(20);
    load = 1'b1; data = 32'h0000_00A5; dp = 8'h04; blank_lz = 1'b1;
    step();
    load = 1'b0;
    go_to(61);
    n_checks++;
    if (seg !== 8'hF9) begin
      n_fail++;
      $display("FAIL blank_pre_boundary: seg=%h, need F9", seg);
    end
    for (int i = 0; i < 8; i++) begin
      go_to(8 * i + 5);
      e_an = ~(8'h01 << i);
      n_checks++;
      if (an !== e_an || seg !== exp_seg[i]) begin
        n_fail++;
        $display("FAIL blank_digit%0d: an=%h seg=%h, need an=%h seg=%h", i, an, seg, e_an, exp_seg[i]);
      end
    end
    go_to(20);
    load = 1'b1; data = 32'd0; dp = 8'h00; blank_lz = 1'b1;
    step();
    load = 1'b0; blank_lz = 1'b0;
    go_to(5);
    n_checks++;
    if (an !== 8'hFE || seg !== 8'hC0) begin
      n_fail++;
      $display("FAIL zero_digit0_lit: an=%h seg=%h, need an=FE seg=C0", an, seg);
    end
    go_to(13);
    n_checks++;
    if (an !== 8'hFD || seg !== 8'hFF) begin
      n_fail++;
      $display("FAIL zero_digit1_blank: an=%h seg=%h, need an=FD seg=FF", an, seg);
    end
  endtask

  task automatic test_back_to_back();
    go_to(30);
    load = 1'b1; data = 32'h8765_4321; dp = 8'h00; blank_lz = 1'b0;
    step();
    load = 1'b0;
    go_to(63);
    load = 1'b1; data = 32'hFEDC_BA90;
    step();
    load = 1'b0;
    n_checks++;
    if (frame_tick !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_tick: tick=%b, need 1", frame_tick);
    end
    go_to(5);
    n_checks++;
    if (seg !== 8'hF9) begin
      n_fail++;
      $display("FAIL b2b_P_digit0: seg=%h, need F9", seg);
    end
    go_to(61);
    n_checks++;
    if (seg !== 8'h80) begin
      n_fail++;
      $display("FAIL b2b_P_digit7: seg=%h, need 80", seg);
    end
    go_to(5);
    n_checks++;
    if (seg !== 8'hC0) begin
      n_fail++;
      $display("FAIL b2b_N_digit0: seg=%h, need C0", seg);
    end
    go_to(61);
    n_checks++;
    if (seg !== 8'h8E) begin
      n_fail++;
      $display("FAIL b2b_N_digit7: seg=%h, need 8E", seg);
    end
    go_to(63);
    load = 1'b1; data = 32'h2222_2222;
    step();
    load = 1'b0;
    go_to(5);
    n_checks++;
    if (seg !== 8'hC0) begin
      n_fail++;
      $display("FAIL boundary_load_no_prior: seg=%h, need C0", seg);
    end
    go_to(61);
    go_to(5);
    n_checks++;
    if (seg !== 8'hA4) begin
      n_fail++;
      $display("FAIL boundary_load_next_frame: seg=%h, need A4", seg);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e_an [3] = '{8'hFF, 8'hFF, 8'hFE};
    logic [7:0] e_seg[3] = '{8'hFF, 8'hFF, 8'hC0};
    go_to(30);
    load = 1'b1; data = 32'h1111_1111;
    step();
    load = 1'b0;
    go_to(44);
    rstn = 1'b0; load = 1'b1; data = 32'hFFFF_FFFF;
    step();
    n_checks++;
    if (seg !== 8'hFF || an !== 8'hFF || frame_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: seg=%h an=%h tick=%b, need FF FF 0", seg, an, frame_tick);
    end
    rstn = 1'b1; load = 1'b0;
    t = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (an !== e_an[k] || seg !== e_seg[k] || frame_tick !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_restart t=%0d: an=%h seg=%h tick=%b, need an=%h seg=%h tick=0",
                 t, an, seg, frame_tick, e_an[k], e_seg[k]);
      end
    end
    go_to(61);
    go_to(5);
    n_checks++;
    if (t !== 69 || an !== 8'hFE || seg !== 8'hC0) begin
      n_fail++;
      $display("FAIL midreset_pending_lost: t=%0d an=%h seg=%h, need t=69 an=FE seg=C0", t, an, seg);
    end
  endtask

  initial begin
    rstn = 1'b0; load = 1'b0; data = 32'd0; dp = 8'd0; blank_lz = 1'b0;
    test_reset();
    test_scan();
    test_load_sync();
    test_blank_lz();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
